// File: rtl/atom_pkg.sv
// Shared definitions for the atom SRAM/boot block: boot FSM states,
// SRAM strobe polarity and the CPU write-protect boundary.
// No logic; imported by atom and atom_spi_boot.
package atom_pkg;

    typedef enum logic [1:0] {
        BOOT_WAIT = 2'd0,
        BOOT_LOAD = 2'd1,
        BOOT_DONE = 2'd2
    } boot_state_t;

    // External SRAM strobes are active-low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    // CPU writes at or above this address hit ROM image space and are dropped.
    localparam logic [15:0] ROM_BASE = 16'hC000;

endpackage

// File: rtl/atom_spi_boot.sv
// Purpose: SPI boot slave -- synchronizes ss/sclk/mosi, shifts bytes MSB first, runs boot FSM.
// Latency: byte_vld pulses ~3 clk cycles after the 8th synchronized sclk rise.
// Backpressure: none on SPI; LOAD->DONE waits until the SRAM writer reports idle (wr_busy=0).
// Ports: clk/rst; ss/sclk/mosi raw SPI pins; wr_busy, boot_full from the SRAM writer;
//        state (boot FSM), byte_vld/byte_dat (completed byte strobe + data).
module atom_spi_boot
    import atom_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ss,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        wr_busy,
    input  logic        boot_full,
    output boot_state_t state,
    output logic        byte_vld,
    output logic [7:0]  byte_dat
);

    // Two-flop synchronizers plus one delay stage for edge detection.
    // Reset to 1 to match the pull-up idle level of the pins.
    logic ss_meta, ss_sync, ss_d;
    logic sclk_meta, sclk_sync, sclk_d;
    logic mosi_meta, mosi_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_d      <= 1'b1;
            sclk_meta <= 1'b1;
            sclk_sync <= 1'b1;
            sclk_d    <= 1'b1;
            mosi_meta <= 1'b1;
            mosi_sync <= 1'b1;
        end else begin
            ss_meta   <= ss;
            ss_sync   <= ss_meta;
            ss_d      <= ss_sync;
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    logic sclk_rise, ss_fall;
    assign sclk_rise = sclk_sync & ~sclk_d;
    assign ss_fall   = ss_d & ~ss_sync;

    boot_state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT_WAIT;
        else     state <= state_nxt;
    end

    // Leaving LOAD (ss released or image space full) is held off while a
    // byte is still being written so the CPU never inherits a live write.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT_WAIT: if (ss_fall) state_nxt = BOOT_LOAD;
            BOOT_LOAD: if ((ss_sync || boot_full) && !wr_busy) state_nxt = BOOT_DONE;
            BOOT_DONE: state_nxt = BOOT_DONE;
            default:   state_nxt = BOOT_WAIT;
        endcase
    end

    logic [6:0] shreg;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_vld <= 1'b0;
            byte_dat <= '0;
        end else begin
            byte_vld <= 1'b0;
            if (state != BOOT_LOAD || ss_sync) begin
                // Any partially shifted byte is dropped when ss goes high.
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], mosi_sync};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_vld <= 1'b1;
                    byte_dat <= {shreg, mosi_sync};
                end
            end
        end
    end

endmodule

// File: rtl/atom.sv
// Purpose: SRAM controller -- SPI boot image load, then 1 MHz CPU bus with clock-enable.
// Latency: boot byte written 6 clk after byte_vld; CPU read data registered at phase DIV-2.
// Backpressure: none; boot owns SRAM in WAIT/LOAD, CPU owns it once cpu_reset drops.
// Ports: clk100/reset; arm_ss/sclk/mosi SPI boot pins; RAMCS_b/OE_b/WE_b, ADR, DAT to SRAM;
//        cpu_clken/cpu_reset to CPU; address/rnw/cpu_dout request, cpu_din read data.
module atom
    import atom_pkg::*;
#(
    parameter logic [17:0] BOOT_START_ADDR = 18'h0C000,
    parameter logic [17:0] BOOT_END_ADDR   = 18'h0FFFF,
    parameter int          CPU_CLKEN_DIV   = 100
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        arm_ss,
    input  logic        arm_sclk,
    input  logic        arm_mosi,
    output logic        RAMCS_b,
    output logic        RAMOE_b,
    output logic        RAMWE_b,
    output logic [17:0] ADR,
    inout  wire  [7:0]  DAT,
    output logic        cpu_clken,
    output logic        cpu_reset,
    input  logic [15:0] address,
    input  logic        rnw,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din
);

    localparam int PW = $clog2(CPU_CLKEN_DIV);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CPU_CLKEN_DIV - 1);
    localparam logic [PW-1:0] PH_CAP   = PW'(CPU_CLKEN_DIV - 2);
    localparam logic [PW-1:0] PH_DRV   = PW'(CPU_CLKEN_DIV / 2 - 1);
    localparam logic [PW-1:0] PH_WE_LO = PW'(CPU_CLKEN_DIV / 2);
    localparam logic [PW-1:0] PH_WE_HI = PW'(CPU_CLKEN_DIV - 3);

    boot_state_t state;
    logic        byte_vld;
    logic [7:0]  byte_dat;
    logic        wr_active;
    logic [2:0]  wr_cnt;
    logic [7:0]  wr_dat;
    logic [17:0] boot_addr;
    logic        boot_full;
    logic        wr_busy;
    logic [PW-1:0] phase;
    logic        dat_oe;
    logic [7:0]  dat_out;

    assign boot_full = (boot_addr > BOOT_END_ADDR);
    assign wr_busy   = wr_active | byte_vld;

    atom_spi_boot u_spi_boot (
        .clk       (clk100),
        .rst       (reset),
        .ss        (arm_ss),
        .sclk      (arm_sclk),
        .mosi      (arm_mosi),
        .wr_busy   (wr_busy),
        .boot_full (boot_full),
        .state     (state),
        .byte_vld  (byte_vld),
        .byte_dat  (byte_dat)
    );

    // Boot write sequence, wr_cnt 0..5: 0 = setup, 1..4 = WE low, 5 = hold.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            wr_active <= 1'b0;
            wr_cnt    <= '0;
            wr_dat    <= '0;
            boot_addr <= BOOT_START_ADDR;
        end else if (wr_active) begin
            if (wr_cnt == 3'd5) begin
                wr_active <= 1'b0;
                wr_cnt    <= '0;
                boot_addr <= boot_addr + 18'd1;
            end else begin
                wr_cnt <= wr_cnt + 3'd1;
            end
        end else if (byte_vld && state == BOOT_LOAD && !boot_full) begin
            wr_active <= 1'b1;
            wr_cnt    <= '0;
            wr_dat    <= byte_dat;
        end
    end

    // cpu_reset trails DONE by one cycle; the phase counter starts with it
    // so the first CPU bus cycle begins at phase 0.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            cpu_reset <= 1'b1;
            phase     <= '0;
            cpu_din   <= '0;
        end else begin
            cpu_reset <= (state != BOOT_DONE);
            if (!cpu_reset) begin
                phase <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
                if (rnw && phase == PH_CAP) cpu_din <= DAT;
            end
        end
    end

    assign cpu_clken = !cpu_reset && (phase == PH_LAST);

    // Strobes decode straight from async-reset registers, so reset pulls
    // RAMWE_b high immediately without waiting for a clock.
    always_comb begin
        RAMCS_b = STROBE_OFF;
        RAMOE_b = STROBE_OFF;
        RAMWE_b = STROBE_OFF;
        ADR     = '0;
        dat_oe  = 1'b0;
        dat_out = '0;
        if (!cpu_reset) begin
            RAMCS_b = STROBE_ON;
            ADR     = {2'b00, address};
            if (rnw) begin
                RAMOE_b = STROBE_ON;
            end else if (address < ROM_BASE) begin
                if (phase >= PH_DRV && phase <= PH_CAP) begin
                    dat_oe  = 1'b1;
                    dat_out = cpu_dout;
                end
                if (phase >= PH_WE_LO && phase <= PH_WE_HI) RAMWE_b = STROBE_ON;
            end
        end else if (wr_active) begin
            RAMCS_b = STROBE_ON;
            ADR     = boot_addr;
            dat_oe  = 1'b1;
            dat_out = wr_dat;
            if (wr_cnt >= 3'd1 && wr_cnt <= 3'd4) RAMWE_b = STROBE_ON;
        end
    end

    assign DAT = dat_oe ? dat_out : 8'hzz;

endmodule

// File: tb/tb_atom.sv
module tb_atom;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        arm_ss, arm_sclk, arm_mosi;
    logic        RAMCS_b, RAMOE_b, RAMWE_b;
    logic [17:0] ADR;
    wire  [7:0]  DAT;
    logic        cpu_clken, cpu_reset;
    logic [15:0] address;
    logic        rnw;
    logic [7:0]  cpu_dout, cpu_din;

    always #5 clk100 = ~clk100;

    // Short 16-byte image window keeps the boot phase small.
    atom #(
        .BOOT_START_ADDR (18'h0C000),
        .BOOT_END_ADDR   (18'h0C00F),
        .CPU_CLKEN_DIV   (100)
    ) dut (
        .clk100    (clk100),
        .reset     (reset),
        .arm_ss    (arm_ss),
        .arm_sclk  (arm_sclk),
        .arm_mosi  (arm_mosi),
        .RAMCS_b   (RAMCS_b),
        .RAMOE_b   (RAMOE_b),
        .RAMWE_b   (RAMWE_b),
        .ADR       (ADR),
        .DAT       (DAT),
        .cpu_clken (cpu_clken),
        .cpu_reset (cpu_reset),
        .address   (address),
        .rnw       (rnw),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din)
    );

    // ---------------- SRAM model and bus monitor ----------------
    logic [7:0]  mem [0:65535];
    wire  [7:0]  sram_q = mem[ADR[15:0]];
    assign DAT = (!RAMCS_b && !RAMOE_b && RAMWE_b) ? sram_q : 8'hzz;

    int          pulse_cnt = 0, last_len = 0, cur_len = 0, viol = 0;
    int          cyc = 0, last_ck = 0, ck_gap = 0, ck_cnt = 0;
    logic [17:0] last_wr_adr = '0;
    logic [7:0]  last_wr_dat = '0;
    logic        we_prev = 1'b1;
    logic [17:0] adr_prev = '0;
    logic [7:0]  dat_prev = '0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h8000] = 8'h20;
        forever begin
            @(negedge clk100);
            cyc++;
            if (reset) begin
                we_prev = 1'b1;
            end else begin
                if (!RAMWE_b && RAMCS_b) viol++;
                if (!RAMOE_b && dut.dat_oe) viol++;
                if (cpu_clken && cpu_reset) viol++;
                if (we_prev && !RAMWE_b) begin
                    cur_len = 1;
                    if (ADR != adr_prev || DAT != dat_prev) viol++;
                end else if (!we_prev && !RAMWE_b) begin
                    cur_len++;
                end else if (!we_prev && RAMWE_b) begin
                    if (ADR != adr_prev || DAT != dat_prev) viol++;
                    last_len = cur_len;
                    pulse_cnt++;
                    mem[adr_prev[15:0]] = dat_prev;
                    last_wr_adr = adr_prev;
                    last_wr_dat = dat_prev;
                end
                if (cpu_clken) begin
                    if (ck_cnt > 0) ck_gap = cyc - last_ck;
                    last_ck = cyc;
                    ck_cnt++;
                end
                we_prev = RAMWE_b;
            end
            adr_prev = ADR;
            dat_prev = DAT;
        end
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            arm_sclk = 1'b0;
            arm_mosi = b[i];
            #25;
            arm_sclk = 1'b1;
            #25;
        end
    endtask

    task automatic wait_clken(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk100);
            #1;
            n++;
        end while (!cpu_clken && n < 300);
        check({name, "_clken_seen"}, {31'd0, cpu_clken}, 32'd1);
    endtask

    typedef struct {
        logic        rnw;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_din;
        int          exp_pulses;
        logic [7:0]  exp_mem;
    } cpu_vec_t;

    cpu_vec_t    vecs [10];
    logic [7:0]  img  [16];
    int          pb, n;

    initial begin
        vecs[0] = '{1'b1, 16'h8000, 8'h00, 8'h20, 0, 8'h20};
        vecs[1] = '{1'b0, 16'h8001, 8'h41, 8'h20, 1, 8'h41};
        vecs[2] = '{1'b1, 16'h8001, 8'h00, 8'h41, 0, 8'h41};
        vecs[3] = '{1'b0, 16'hC000, 8'h55, 8'h41, 0, 8'h77};
        vecs[4] = '{1'b1, 16'hC000, 8'h00, 8'h77, 0, 8'h77};
        vecs[5] = '{1'b1, 16'hC00F, 8'h00, 8'hBF, 0, 8'hBF};
        vecs[6] = '{1'b0, 16'hBFFF, 8'h9C, 8'hBF, 1, 8'h9C};
        vecs[7] = '{1'b1, 16'hBFFF, 8'h00, 8'h9C, 0, 8'h9C};
        vecs[8] = '{1'b0, 16'hFFFF, 8'h01, 8'h9C, 0, 8'h00};
        vecs[9] = '{1'b1, 16'h0000, 8'h00, 8'h00, 0, 8'h00};
        img[0] = 8'h77;
        for (int i = 1; i < 16; i++) img[i] = 8'hB0 + 8'(i);

        reset = 1'b1; arm_ss = 1'b1; arm_sclk = 1'b1; arm_mosi = 1'b1;
        address = '0; rnw = 1'b1; cpu_dout = '0;
        #35 reset = 1'b0;

        // Idle 1 us with ss high.
        repeat (100) @(negedge clk100);
        #1;
        check("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("idle_cpu_clken_cnt", ck_cnt, 0);
        check("idle_we", {31'd0, RAMWE_b}, 32'd1);
        check("idle_cs_oe", {30'd0, RAMCS_b, RAMOE_b}, 32'd3);
        check("idle_adr", {14'd0, ADR}, 32'd0);
        check("idle_cpu_din", {24'd0, cpu_din}, 32'd0);
        check("idle_dat_float", {31'd0, dut.dat_oe}, 32'd0);
        check("idle_pulses", pulse_cnt, 0);

        // Two bytes, then a 5-bit fragment that must be dropped.
        arm_ss = 1'b0; #100;
        spi_byte(8'hA5, 8);
        spi_byte(8'h3C, 8);
        #300;
        check("boot_mem_c000", {24'd0, mem[16'hC000]}, 32'hA5);
        check("boot_mem_c001", {24'd0, mem[16'hC001]}, 32'h3C);
        check("boot_pulses_2", pulse_cnt, 2);
        check("boot_we_width", last_len, 4);
        check("boot_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);
        spi_byte(8'hF0, 5);
        arm_ss = 1'b1;
        #300;
        check("partial_pulses", pulse_cnt, 2);
        check("partial_mem_c002", {24'd0, mem[16'hC002]}, 32'h00);
        check("ss_rise_done", {31'd0, cpu_reset}, 32'd0);

        // Reset restarts boot; three bytes, then abort the fourth write.
        reset = 1'b1; #20 reset = 1'b0;
        #1 check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        #100;
        pb = pulse_cnt;
        arm_ss = 1'b0; #100;
        spi_byte(8'h10, 8);
        spi_byte(8'h11, 8);
        spi_byte(8'h12, 8);
        #300;
        check("b_mem_c002", {24'd0, mem[16'hC002]}, 32'h12);
        check("b_pulses_3", pulse_cnt - pb, 3);
        spi_byte(8'h99, 8);
        n = 0;
        do begin
            @(posedge clk100); #1; n++;
        end while (RAMWE_b && n < 50);
        check("abort_we_seen_low", {31'd0, RAMWE_b}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_we_async", {31'd0, RAMWE_b}, 32'd1);
        check("abort_adr", {14'd0, ADR}, 32'd0);
        arm_ss = 1'b1;
        #30 reset = 1'b0;
        #100;

        // Full (short) image from 0x77; image end must end the boot with ss low.
        pb = pulse_cnt;
        arm_ss = 1'b0; #100;
        for (int i = 0; i < 16; i++) spi_byte(img[i], 8);
        #300;
        check("img_mem_c000", {24'd0, mem[16'hC000]}, 32'h77);
        check("img_mem_c00f", {24'd0, mem[16'hC00F]}, 32'hBF);
        check("img_last_adr", {14'd0, last_wr_adr}, 32'h0C00F);
        check("img_pulses", pulse_cnt - pb, 16);
        check("img_done_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        spi_byte(8'hE1, 8);
        arm_ss = 1'b1;
        #300;
        check("img_beyond_end", {24'd0, mem[16'hC010]}, 32'h00);
        check("img_pulses_after", pulse_cnt - pb, 16);

        // Clock-enable cadence.
        wait_clken("cad1");
        wait_clken("cad2");
        check("clken_gap", ck_gap, 100);

        // Boot pins wiggle after DONE: no effect.
        pb = pulse_cnt;
        arm_ss = 1'b0; #100;
        spi_byte(8'h5A, 8);
        arm_ss = 1'b1;
        #300;
        check("float_pulses", pulse_cnt - pb, 0);
        check("float_cpu_reset", {31'd0, cpu_reset}, 32'd0);

        // CPU bus vectors.
        wait_clken("cpu_start");
        for (int v = 0; v < 10; v++) begin
            address  = vecs[v].a;
            rnw      = vecs[v].rnw;
            cpu_dout = vecs[v].d;
            pb       = pulse_cnt;
            wait_clken($sformatf("v%0d", v));
            check($sformatf("v%0d_din", v), {24'd0, cpu_din}, {24'd0, vecs[v].exp_din});
            check($sformatf("v%0d_pulses", v), pulse_cnt - pb, vecs[v].exp_pulses);
            check($sformatf("v%0d_mem", v), {24'd0, mem[vecs[v].a]}, {24'd0, vecs[v].exp_mem});
            if (vecs[v].exp_pulses == 1) begin
                check($sformatf("v%0d_wr_adr", v), {14'd0, last_wr_adr}, {16'd0, vecs[v].a});
                check($sformatf("v%0d_wr_dat", v), {24'd0, last_wr_dat}, {24'd0, vecs[v].d});
                check($sformatf("v%0d_we_width", v), last_len, 48);
            end
        end

        check("bus_protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/atom.md
ATOM -- requirements
Module: atom

Interface
REQ-001 Parameter BOOT_START_ADDR, default 'h0C000, first SRAM address written by the SPI boot loader.
REQ-002 Parameter BOOT_END_ADDR, default 'h0FFFF, last SRAM address written by the boot loader.
REQ-003 Parameter CPU_CLKEN_DIV, default 100, clk100 cycles per CPU bus cycle (1 MHz).
REQ-004 clk100  input  1  system clock, 100 MHz; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 arm_ss, arm_sclk, arm_mosi  input  1 each  SPI boot slave (select active-low, MSB first, sampled on sclk rising edge); undriven pins read as 1 (pull-up).
REQ-007 RAMCS_b, RAMOE_b, RAMWE_b  output  1 each  external SRAM strobes, active-low.
REQ-008 ADR  output  18  SRAM address; DAT  inout  8  SRAM data.
REQ-009 cpu_clken  output  1  one-cycle CPU clock-enable pulse; cpu_reset  output  1  CPU reset, active-high.
REQ-010 address  input  16, rnw  input  1, cpu_dout  input  8: CPU bus request; cpu_din  output  8: read data.

Function
REQ-011 arm_ss, arm_sclk, arm_mosi SHALL pass through two-flop synchronizers; sclk rising edge detected on synchronized signal.
REQ-012 Boot FSM states: WAIT (ss high), LOAD (ss low), DONE; WAIT->LOAD on ss falling; LOAD->DONE on ss rising or after BOOT_END_ADDR byte written; DONE terminal until reset.
REQ-013 In LOAD each sclk rise SHALL shift mosi into an 8-bit register MSB first; 8th bit completes a byte.
REQ-014 Each completed byte SHALL be written to SRAM at current boot address (start BOOT_START_ADDR, +1 per byte); write SHALL finish within 20 clk100 cycles (next byte arrives after 40 at 20 MHz SPI).
REQ-015 Boot write: ADR/DAT stable 1 cycle before RAMWE_b falls, RAMWE_b low 4 cycles, ADR/DAT held 1 cycle after RAMWE_b rises; RAMCS_b low, RAMOE_b high throughout.
REQ-016 Partial byte when ss rises SHALL be discarded; bytes beyond BOOT_END_ADDR SHALL be ignored.
REQ-017 cpu_reset SHALL be 1 in WAIT and LOAD and fall 1 cycle after entering DONE; cpu_clken SHALL be 0 while cpu_reset is 1.
REQ-018 In DONE a phase counter 0..CPU_CLKEN_DIV-1 SHALL run; cpu_clken=1 only at phase DIV-1.
REQ-019 CPU cycle: ADR={2'b00,address}, RAMCS_b=0 whole cycle.
REQ-020 Read (rnw=1): RAMOE_b=0, RAMWE_b=1, DAT Z; cpu_din registered from DAT at phase DIV-2, held until next capture.
REQ-021 Write (rnw=0): RAMOE_b=1; DAT driven with cpu_dout phases DIV/2-1..DIV-2; RAMWE_b low phases DIV/2..DIV-3.
REQ-022 CPU writes with address >= 'hC000 SHALL be suppressed (RAMWE_b stays 1, DAT Z); reads unaffected.
REQ-023 DAT SHALL be driven only while the block itself writes; never with RAMOE_b=0.
REQ-024 Boot loader owns SRAM in WAIT/LOAD; CPU bus owns it in DONE; no arbitration otherwise.

Reset
REQ-025 On reset: FSM=WAIT, boot address=BOOT_START_ADDR, shift count 0, phase 0, cpu_reset=1, cpu_clken=0, cpu_din=0, RAMCS_b=RAMOE_b=RAMWE_b=1, ADR=0, DAT Z.
REQ-026 Reset mid-boot or mid-write SHALL abort immediately (RAMWE_b to 1 asynchronously); load restarts at BOOT_START_ADDR on next ss fall.

Structure
REQ-027 Shared package: boot FSM state enum, SRAM strobe polarity constants, ROM write-protect base 'hC000.
REQ-028 One sub-module atom_spi_boot (synchronizers, shifter, byte-ready strobe, boot FSM); SRAM sequencing and clken in atom.

Verification
REQ-029 Reset then 1 us idle, ss high -> cpu_reset=1, cpu_clken=0, RAMWE_b=1, DAT Z.
REQ-030 ss low, bytes 0xA5, 0x3C at 20 MHz -> SRAM writes 0x0C000=0xA5, 0x0C001=0x3C, one RAMWE_b pulse each.
REQ-031 Full 16 KB image then ss high -> last write at 0x0FFFF, cpu_reset falls, cpu_clken every 100 cycles, bootloader pins floated without effect.
REQ-032 After boot, SRAM[0x8000]=0x20, CPU read 0x8000 -> cpu_din=0x20 at cpu_clken.
REQ-033 CPU write 0x8001=0x41 -> one RAMWE_b pulse, ADR=0x08001, DAT=0x41; write 0xC000=0x55 -> no RAMWE_b pulse, SRAM unchanged.
REQ-034 Reset after 3 bytes loaded, then reload 1 byte 0x77 -> written at 0x0C000.
